// File: rtl/ex_mem_stage.sv
// ex_mem_stage: merges the gated execute op results into one result word,
// bundles it with destination and memory-control fields, and passes the packet
// to the memory stage through a 2-entry skid buffer with registered
// valid/ready on both sides.
module ex_mem_stage #(
    parameter int XLEN = 32,
    parameter int NOPS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NOPS*XLEN-1:0] op_aer,
    input  logic [NOPS-1:0]      op_en,
    input  logic [4:0]           in_rd,
    input  logic                 in_wb_en,
    input  logic                 in_mem_rd,
    input  logic                 in_mem_wr,
    input  logic [1:0]           in_mem_size,
    input  logic [XLEN-1:0]      in_store_data,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [4:0]           out_rd,
    output logic                 out_wb_en,
    output logic                 out_mem_rd,
    output logic                 out_mem_wr,
    output logic [1:0]           out_mem_size,
    output logic [XLEN-1:0]      out_store_data,
    output logic [XLEN-1:0]      out_pc,
    output logic                 out_err
);

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] store_data;
        logic [1:0]      mem_size;
        logic            mem_wr;
        logic            mem_rd;
        logic            wb_en;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
    } pkt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [NOPS-1:0] EN_LSB = NOPS'(1);

    state_t          state_reg;
    state_t          state_next;
    logic            out_valid_reg;
    logic            in_ready_reg;
    pkt_t            main_reg;
    pkt_t            skid_reg;
    pkt_t            in_pkt;
    logic [XLEN-1:0] op_slice [NOPS];
    logic [XLEN-1:0] merged;
    logic            multi_hot;
    logic            accept;
    logic            drain;
    logic            load_main_in;
    logic            load_main_skid;
    logic            load_skid_in;

    // Split the concatenated op results into per-op slices.
    generate
        for (genvar gi = 0; gi < NOPS; gi++) begin : g_slice
            assign op_slice[gi] = op_aer[gi*XLEN +: XLEN];
        end
    endgenerate

    // OR-merge all gated results; only the enabled op drives non-zero data.
    always_comb begin
        merged = '0;
        for (int i = 0; i < NOPS; i++) begin
            merged = merged | op_slice[i];
        end
    end

    // More than one enable set: clearing the lowest set bit leaves something.
    assign multi_hot = |(op_en & (op_en - EN_LSB));

    // Build the incoming packet; a malformed enable vector is neutralised.
    always_comb begin
        in_pkt            = '0;
        in_pkt.err        = multi_hot;
        in_pkt.pc         = in_pc;
        in_pkt.store_data = in_store_data;
        in_pkt.mem_size   = in_mem_size;
        in_pkt.mem_wr     = in_mem_wr & ~multi_hot;
        in_pkt.mem_rd     = in_mem_rd & ~multi_hot;
        in_pkt.wb_en      = in_wb_en & ~multi_hot;
        in_pkt.rd         = in_rd;
        in_pkt.result     = multi_hot ? '0 : merged;
    end

    assign accept = in_valid & in_ready_reg;
    assign drain  = out_valid_reg & out_ready;

    // State register with registered handshake flags derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= (state_next != EMPTY);
            in_ready_reg  <= (state_next != TWO);
        end
    end

    // Next-state logic; flush empties the buffer unconditionally.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (accept) state_next = ONE;
            ONE: begin
                if (accept && !drain)      state_next = TWO;
                else if (!accept && drain) state_next = EMPTY;
                else                       state_next = ONE;
            end
            TWO: if (drain) state_next = ONE;
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    // Load controls for the main and skid entries; nothing loads during flush.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (!flush) begin
            case (state_reg)
                EMPTY: load_main_in = accept;
                ONE: begin
                    load_main_in = accept & drain;
                    load_skid_in = accept & ~drain;
                end
                TWO: load_main_skid = drain;
                default: ;
            endcase
        end
    end

    // Main entry: drives the outputs, changes only on a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg <= '0;
        end else if (load_main_in) begin
            main_reg <= in_pkt;
        end else if (load_main_skid) begin
            main_reg <= skid_reg;
        end
    end

    // Skid entry: catches the beat accepted while the main entry is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_reg <= '0;
        end else if (load_skid_in) begin
            skid_reg <= in_pkt;
        end
    end

    assign in_ready       = in_ready_reg;
    assign out_valid      = out_valid_reg;
    assign out_result     = main_reg.result;
    assign out_rd         = main_reg.rd;
    assign out_wb_en      = main_reg.wb_en;
    assign out_mem_rd     = main_reg.mem_rd;
    assign out_mem_wr     = main_reg.mem_wr;
    assign out_mem_size   = main_reg.mem_size;
    assign out_store_data = main_reg.store_data;
    assign out_pc         = main_reg.pc;
    assign out_err        = main_reg.err;

endmodule
